// File: rtl/sub_share_pkg.sv
// Shared defaults and the operand-stage payload for the shared subtractor arbiter.
package sub_share_pkg;

  localparam int SS_W   = 8;
  localparam int SS_N   = 4;
  localparam int SS_IDW = 2;

  typedef struct packed {
    logic [SS_W-1:0]   a;
    logic [SS_W-1:0]   b;
    logic              bin;
    logic [SS_IDW-1:0] id;
  } s1_payload_t;

endpackage

// File: rtl/sub_share_arbiter_rr.sv
// Round-robin arbiter: one-hot grant searching from ptr upward, ptr moves past the winner.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id
);

  logic [IDW-1:0] ptr_q, ptr_d;

  always_comb begin : search
    logic found;
    int   idx;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= N) idx = idx - N;
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Every grant is an accept, so the pointer advances exactly when a grant is issued.
  always_comb begin
    ptr_d = ptr_q;
    if (|grant) begin
      ptr_d = (int'(grant_id) == N - 1) ? '0 : IDW'(int'(grant_id) + 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sub_share_arbiter.sv
// Shares one W-bit subtractor among N requesters: RR arbiter, operand stage, result stage.
module sub_share_arbiter
  import sub_share_pkg::*;
#(
  parameter int W   = SS_W,
  parameter int N   = SS_N,
  parameter int IDW = SS_IDW
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  logic [N-1:0]   req_valid,
  output logic [N-1:0]   req_ready,
  input  logic [N*W-1:0] req_a,
  input  logic [N*W-1:0] req_b,
  input  logic [N-1:0]   req_bin,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [IDW-1:0] rsp_id,
  output logic [W-1:0]   rsp_diff,
  output logic           rsp_borrow,
  output logic           busy
);

  logic           s1_vld_q, s1_vld_d;
  s1_payload_t    s1_q, s1_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [W-1:0]   rsp_diff_q, rsp_diff_d;
  logic           rsp_borrow_q, rsp_borrow_d;

  logic           s2_free, s1_free, arb_en;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic [W:0]     sub_res;

  assign s2_free = !rsp_valid_q || rsp_ready;
  assign s1_free = !s1_vld_q || s2_free;
  // Gating with rst_n keeps req_ready low for the whole time reset is held.
  assign arb_en  = s1_free && !flush && rst_n;

  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (arb_en),
    .req      (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign sub_res = {1'b0, s1_q.a} - {1'b0, s1_q.b} - {{W{1'b0}}, s1_q.bin};

  always_comb begin
    s1_vld_d     = s1_vld_q;
    s1_d         = s1_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_diff_d   = rsp_diff_q;
    rsp_borrow_d = rsp_borrow_q;
    if (flush) begin
      s1_vld_d    = 1'b0;
      rsp_valid_d = 1'b0;
    end else begin
      if (s2_free) begin
        rsp_valid_d = s1_vld_q;
        if (s1_vld_q) begin
          rsp_id_d     = s1_q.id;
          rsp_diff_d   = sub_res[W-1:0];
          rsp_borrow_d = sub_res[W];
        end
      end
      if (|grant) begin
        s1_vld_d = 1'b1;
        s1_d.a   = req_a[int'(grant_id)*W +: W];
        s1_d.b   = req_b[int'(grant_id)*W +: W];
        s1_d.bin = req_bin[grant_id];
        s1_d.id  = grant_id;
      end else if (s2_free) begin
        s1_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_diff_q   <= '0;
      rsp_borrow_q <= 1'b0;
    end else begin
      s1_vld_q     <= s1_vld_d;
      s1_q         <= s1_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_diff_q   <= rsp_diff_d;
      rsp_borrow_q <= rsp_borrow_d;
    end
  end

  assign req_ready  = grant;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_diff   = rsp_diff_q;
  assign rsp_borrow = rsp_borrow_q;
  assign busy       = s1_vld_q || rsp_valid_q;

endmodule

// File: tb/tb_sub_share_arbiter.sv
// Directed bench for sub_share_arbiter: driver pushes expected results, negedge monitor pops and compares.
module tb_sub_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_bin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_diff;
  logic        rsp_borrow;
  logic        busy;

  always #5 clk = ~clk;

  sub_share_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_bin    (req_bin),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow),
    .busy       (busy)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] diff;
    logic       borrow;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Operands and hand-computed results for the four-way round-robin burst.
  logic [7:0] t4_a  [4] = '{8'h20, 8'h10, 8'h33, 8'h01};
  logic [7:0] t4_b  [4] = '{8'h10, 8'h20, 8'h11, 8'h00};
  logic       t4_bin[4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] t4_d  [4] = '{8'h10, 8'hF0, 8'h21, 8'h00};
  logic       t4_bo [4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic bin);
    req_a[i*8 +: 8] = a;
    req_b[i*8 +: 8] = b;
    req_bin[i]      = bin;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] d, input logic bo);
    exp_t e;
    e.id     = id;
    e.diff   = d;
    e.borrow = bo;
    sb_q.push_back(e);
    $display("issue: id=%0d exp_diff=%02h exp_borrow=%0d", id, d, bo);
  endtask

  // Monitor: pops one expected entry per delivered response, and checks stall stability.
  initial begin : monitor
    logic        hold_prev;
    logic [10:0] prev;
    exp_t        e;
    hold_prev = 1'b0;
    prev      = '0;
    forever begin
      @(negedge clk);
      if (hold_prev)
        chk("stall_stable", 32'({rsp_id, rsp_diff, rsp_borrow}), 32'(prev));
      hold_prev = rsp_valid && !rsp_ready && !flush && rst_n;
      prev      = {rsp_id, rsp_diff, rsp_borrow};
      if (rst_n && rsp_valid && rsp_ready && !flush) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got id=%0d diff=%02h borrow=%0d, expected no response",
                   rsp_id, rsp_diff, rsp_borrow);
        end else begin
          e = sb_q.pop_front();
          $display("rsp: id=%0d diff=%02h borrow=%0d (exp id=%0d diff=%02h borrow=%0d)",
                   rsp_id, rsp_diff, rsp_borrow, e.id, e.diff, e.borrow);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_diff", 32'(rsp_diff), 32'(e.diff));
          chk("rsp_borrow", 32'(rsp_borrow), 32'(e.borrow));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int waited;
    rst_n     = 1'b0;
    flush     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'hF;
    req_a     = '0;
    req_b     = '0;
    req_bin   = '0;

    // Reset state, including across a clock edge with all requests asserted.
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rsp_data", 32'({rsp_id, rsp_diff, rsp_borrow}), 32'h0);
    step();
    chk("rst_edge_req_ready", 32'(req_ready), 32'h0);
    chk("rst_edge_busy", 32'(busy), 32'h0);
    @(negedge clk);
    req_valid = 4'h0;
    rst_n     = 1'b1;
    #1;
    chk("rel_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rel_busy", 32'(busy), 32'h0);
    step();

    // Single request from requester 2, with latency check.
    set_req(2, 8'h05, 8'h03, 1'b0);
    req_valid = 4'b0100;
    #1 chk("t2_grant", 32'(req_ready), 32'b0100);
    push(2'd2, 8'h02, 1'b0);
    step();
    req_valid = 4'b0000;
    #1;
    chk("t2_busy", 32'(busy), 32'h1);
    chk("t2_valid_early", 32'(rsp_valid), 32'h0);
    step();
    chk("t2_valid_lat2", 32'(rsp_valid), 32'h1);

    // Borrow boundaries, back-to-back single requesters.
    set_req(3, 8'h00, 8'h01, 1'b1);
    req_valid = 4'b1000;
    #1 chk("t3_grant_a", 32'(req_ready), 32'b1000);
    push(2'd3, 8'hFE, 1'b1);
    step();
    set_req(1, 8'hFF, 8'hFF, 1'b0);
    req_valid = 4'b0010;
    #1 chk("t3_grant_b", 32'(req_ready), 32'b0010);
    push(2'd1, 8'h00, 1'b0);
    step();
    set_req(3, 8'h80, 8'h7F, 1'b1);
    req_valid = 4'b1000;
    #1 chk("t3_grant_c", 32'(req_ready), 32'b1000);
    push(2'd3, 8'h00, 1'b0);
    step();
    req_valid = 4'b0000;
    step();
    step();

    // All four requesting: grants 0,1,2,3,0 on consecutive cycles.
    for (int i = 0; i < 4; i++) set_req(i, t4_a[i], t4_b[i], t4_bin[i]);
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t4_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      push(2'(k % 4), t4_d[k % 4], t4_bo[k % 4]);
      step();
    end
    req_valid = 4'b0000;
    step();
    step();

    // Backpressure for three cycles with traffic pending.
    set_req(0, 8'h11, 8'h22, 1'b0);
    set_req(1, 8'h7F, 8'h80, 1'b0);
    set_req(2, 8'hFF, 8'h00, 1'b1);
    set_req(3, 8'h00, 8'hFF, 1'b1);
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1 chk("t5_grant_c0", 32'(req_ready), 32'b0010);
    push(2'd1, 8'hFF, 1'b1);
    step();
    rsp_ready = 1'b0;
    #1 chk("t5_grant_c1", 32'(req_ready), 32'b0100);
    push(2'd2, 8'hFE, 1'b0);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("t5_stall_ready", 32'(req_ready), 32'h0);
      chk("t5_stall_valid", 32'(rsp_valid), 32'h1);
      chk("t5_stall_busy", 32'(busy), 32'h1);
      step();
    end
    rsp_ready = 1'b1;
    #1 chk("t5_grant_resume", 32'(req_ready), 32'b1000);
    push(2'd3, 8'h00, 1'b1);
    step();
    req_valid = 4'b0000;
    step();
    step();
    step();

    // Flush with both stages full; the pointer must survive it.
    set_req(0, 8'h09, 8'h01, 1'b0);
    set_req(1, 8'h09, 8'h02, 1'b0);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1 chk("t6_fill_0", 32'(req_ready), 32'b0001);
    step();
    #1 chk("t6_fill_1", 32'(req_ready), 32'b0010);
    step();
    rsp_ready = 1'b1;
    flush     = 1'b1;
    #1;
    chk("t6_flush_no_grant", 32'(req_ready), 32'h0);
    chk("t6_full_busy", 32'(busy), 32'h1);
    sb_q.delete();
    step();
    flush     = 1'b0;
    req_valid = 4'b0000;
    #1;
    chk("t6_post_valid", 32'(rsp_valid), 32'h0);
    chk("t6_post_busy", 32'(busy), 32'h0);
    set_req(2, 8'h40, 8'h41, 1'b0);
    req_valid = 4'hF;
    #1 chk("t6_ptr_kept", 32'(req_ready), 32'b0100);
    push(2'd2, 8'hFF, 1'b1);
    step();
    req_valid = 4'b0000;

    // Drain with a bounded wait.
    waited = 0;
    while ((sb_q.size() != 0 || busy) && waited < 20) begin
      step();
      waited++;
    end
    @(negedge clk);
    chk("drain_queue_empty", 32'(sb_q.size()), 32'h0);
    chk("drain_busy", 32'(busy), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
